// File: rtl/fx_pkg.sv
// Shared types and constants for the fixed-point multiplier datapath.
// Q15.16 operands, Q30.32 products.
package fx_pkg;

  typedef logic [31:0] fx_t;
  typedef logic [63:0] prod_t;

  localparam int FX_FRAC   = 16;
  localparam int MUL_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX
  } state_t;

endpackage

// File: rtl/fx_abs.sv
// Combinational two's-complement absolute value.
// The result is unsigned, so the most negative input maps exactly.
module fx_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] mag
);

  assign mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/fx_mul_seq.sv
// Sequential signed fixed-point multiplier (radix-2 shift-add).
// Produces the product word, the negated slice and overflow flags.
module fx_mul_seq
  import fx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH/2-1:0]   signedResult,
  output logic                 overflowHigh,
  output logic                 overflowShift,
  output logic                 sign
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   count;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic            sgn;
  logic            fix_sign;

  fx_abs #(.WIDTH(WIDTH)) u_abs_a (
    .a   (opA),
    .mag (abs_a)
  );

  fx_abs #(.WIDTH(WIDTH)) u_abs_b (
    .a   (opB),
    .mag (abs_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = MUL;
      MUL:  if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  // A zero product never carries a negative sign.
  assign neg      = ~acc + PW'(1);
  assign fix_sign = sgn & (|acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      acc           <= '0;
      ma            <= '0;
      mb            <= '0;
      sgn           <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      signedResult  <= '0;
      overflowHigh  <= 1'b0;
      overflowShift <= 1'b0;
      sign          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ma    <= abs_a;
            mb    <= abs_b;
            sgn   <= opA[WIDTH-1] ^ opB[WIDTH-1];
            acc   <= '0;
            count <= '0;
          end
        end
        MUL: begin
          if (mb[count])
            acc <= acc + ({{WIDTH{1'b0}}, ma} << count);
          count <= count + 1'b1;
        end
        FIX: begin
          result        <= fix_sign ? neg : acc;
          signedResult  <= neg[WIDTH+FRAC-1 -: WIDTH/2];
          overflowHigh  <= |acc[PW-1:WIDTH+FRAC];
          overflowShift <= acc[WIDTH+FRAC-1];
          sign          <= fix_sign;
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_mul_seq.sv
// Bench for fx_mul_seq: directed and random products against an
// arithmetic reference, plus handshake, throughput and reset cases.
module tb_fx_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        ready;
  logic        done;
  logic [63:0] result;
  logic [15:0] signedResult;
  logic        overflowHigh;
  logic        overflowShift;
  logic        sign;

  int  checks = 0;
  int  errors = 0;
  time last_done = 0;

  always #5 clk = ~clk;

  fx_mul_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .opA           (opA),
    .opB           (opB),
    .ready         (ready),
    .done          (done),
    .result        (result),
    .signedResult  (signedResult),
    .overflowHigh  (overflowHigh),
    .overflowShift (overflowShift),
    .sign          (sign)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mag(input logic [31:0] x);
    longint s;
    s = longint'(signed'(x));
    return (s < 0) ? 64'(-s) : 64'(s);
  endfunction

  task automatic check_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] n;
    logic        s;
    p = mag(a) * mag(b);
    n = 64'd0 - p;
    s = (a[31] != b[31]) && (p != 64'd0);
    chk("result", result, s ? n : p);
    chk("signedResult", 64'(signedResult), 64'(n[47:32]));
    chk("overflowHigh", 64'(overflowHigh), 64'(p[63:48] != 16'd0));
    chk("overflowShift", 64'(overflowShift), 64'(p[47]));
    chk("sign", 64'(sign), 64'(s));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input bit hold);
    int n;
    logic [63:0] prev;
    chk("ready_idle", 64'(ready), 64'd1);
    prev  = result;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    opA = $urandom;
    opB = $urandom;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 5) begin
        chk("busy_ready", 64'(ready), 64'd0);
        chk("busy_hold", result, prev);
        if (poke) start = 1'b1;
      end
      if (poke && n == 6) start = 1'b0;
      if (done) break;
    end
    chk("latency", 64'(n), 64'd33);
    last_done = $time;
    check_model(a, b);
  endtask

  initial begin
    int pulses;
    time t1;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0;
    start = 1'b0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_sr", 64'(signedResult), 64'd0);
    chk("rst_flags", 64'({overflowHigh, overflowShift}), 64'd0);
    chk("rst_sign", 64'(sign), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready), 64'd1);

    run_op(32'h00018000, 32'h00020000, 0, 0);
    chk("dir_1p5x2", result, 64'h0000000300000000);

    run_op(32'hFFFE8000, 32'h00020000, 0, 0);
    chk("dir_neg_res", result, 64'hFFFFFFFD00000000);
    chk("dir_neg_sr", 64'(signedResult), 64'hFFFD);
    chk("dir_neg_sign", 64'(sign), 64'd1);

    run_op(32'h7FFF0000, 32'h00020000, 0, 0);
    chk("dir_ovs", 64'({overflowHigh, overflowShift}), 64'b01);

    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0);
    chk("dir_ovh", 64'(overflowHigh), 64'd1);

    run_op(32'h00000000, 32'hFFFF0000, 0, 0);
    chk("dir_zero_res", result, 64'd0);
    chk("dir_zero_sign", 64'(sign), 64'd0);

    run_op(32'h80000000, 32'h80000000, 0, 0);
    run_op(32'h80000000, 32'h00010000, 0, 0);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) a = 32'(signed'(a) >>> 12);
      if (i % 4 == 1) b = 32'(signed'(b) >>> 14);
      run_op(a, b, 0, 0);
    end

    run_op($urandom, $urandom, 1, 0);
    pulses = 0;
    repeat (36) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("busy_no_extra_done", 64'(pulses), 64'd0);

    run_op($urandom, $urandom, 0, 1);
    t1 = last_done;
    run_op($urandom, $urandom, 0, 0);
    chk("b2b_gap", 64'(last_done - t1), 64'd340);

    @(negedge clk);
    opA   = 32'hFFFE8000;
    opB   = 32'h00020000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_sr", 64'(signedResult), 64'd0);
    chk("abort_flags", 64'({overflowHigh, overflowShift, sign}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    run_op(32'h00018000, 32'h00020000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx_mul_seq.md
Name: fx_mul_seq

Overview:
Sequential signed fixed-point multiplier for the IIR datapath. It accepts two Q15.16 two's-complement operands over a start/ready handshake and forms the product magnitude with a radix-2 shift-add loop. It then produces the sign, the 64-bit result word, the negated upper slice and the two overflow flags consumed by the saturating output packer. It is the producing end of the product/flags interface: its outputs feed the packer's result, signedResult, overflowHigh, overflowShift and sign inputs directly.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits.
FRAC, 16, fractional bits per operand; the product carries 2*FRAC fractional bits.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only while ready=1.
opA  in  WIDTH  multiplicand, Q15.16 two's complement.
opB  in  WIDTH  multiplier, Q15.16 two's complement.
ready  out  1  high in IDLE; a new operation can be accepted.
done  out  1  one-cycle pulse; all product outputs are valid from this cycle onward.
result  out  2*WIDTH  product word: magnitude P if sign=0, two's complement of P if sign=1.
signedResult  out  WIDTH/2  bits [47:32] of the negated product (two's complement of P).
overflowHigh  out  1  P[63:48] != 0.
overflowShift  out  1  P[47] = 1, i.e. the product reaches the output sign position.
sign  out  1  product sign, opA[31] XOR opB[31]; forced to 0 when P = 0.

Behaviour:
- Reset: state=IDLE, ready=1, done=0. result, signedResult, overflowHigh, overflowShift and sign are all 0. Internal count and accumulator are cleared.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced for it.
- States: IDLE -> MUL -> FIX -> IDLE.
- IDLE: on an edge with start=1, the block latches |opA|, |opB| (32-bit unsigned, so |0x80000000| = 0x80000000 is exact) and the XOR of the two operand sign bits. It clears the accumulator, sets count=0 and enters MUL. ready falls on that edge.
- MUL: 32 iterations, one per cycle. In iteration i, if bit i of |opB| is set, the accumulator gains |opA| << i (64-bit add, no truncation). After count=31 the block goes to FIX.
- FIX (one cycle), with P = accumulator:
  - overflowHigh = |P[63:48]; overflowShift = P[47].
  - sign = latched sign AND (P != 0).
  - result = sign ? (~P + 1) : P.
  - signedResult = (~P + 1)[47:32], registered regardless of sign.
  - All of these are registered on the FIX exit edge. done=1 and ready=1 for the following cycle, and state returns to IDLE.
- Latency: start is accepted at edge E0. Iterations occur at edges E1..E32. Outputs and done are registered at E33 and visible in cycle 33; done is low again after E34 unless a new result completes.
- Throughput: a start sampled in the same cycle as done is accepted, giving back-to-back operations every 34 cycles.
- start while ready=0 is ignored and not queued. opA and opB are sampled only at acceptance.
- Product outputs hold their last value until the next FIX; they do not change during MUL.
- Overflow flags are computed from the magnitude P, never from the negated word. Saturation itself is the downstream packer's job.

Decomposition:
- Shared package fx_pkg holds:
  - typedef fx_t as logic [31:0] and typedef prod_t as logic [63:0];
  - localparams FX_FRAC=16 and MUL_STEPS=32;
  - the state enum {IDLE, MUL, FIX}.
- One sub-module is natural: fx_abs, a combinational two's-complement absolute value returning a WIDTH-bit unsigned magnitude. It is instantiated twice, once per operand.
- The control FSM and the accumulator stay in fx_mul_seq.

Test Plan:
- opA=0x00018000 (1.5), opB=0x00020000 (2.0), start -> done in cycle 33. Expect result=0x0000000300000000, sign=0, overflowHigh=0, overflowShift=0; packer yields 0x00030000.
- opA=0xFFFE8000 (-1.5), opB=0x00020000 -> sign=1, result=0xFFFFFFFD00000000, signedResult=0xFFFD, both flags 0; packer yields 0xFFFD0000.
- opA=0x7FFF0000, opB=0x00020000 -> P=0x0000FFFE00000000, overflowShift=1, overflowHigh=0, sign=0. Then opA=opB=0x7FFFFFFF -> overflowHigh=1.
- opA=0x00000000, opB=0xFFFF0000 (0 × -1.0) -> sign=0, result=0, signedResult=0x0000.
- Handshake and reset:
  - Pulse start at cycle 5 of a busy operation -> ignored; exactly one done, at cycle 33.
  - Hold start high across done -> second op accepted and done again 34 cycles later.
  - Drop rst_n at cycle 10 of an operation -> immediate ready=1 with all outputs 0, and no done pulse.
